frame_packer: RTL and testbench
===============================

FRAME_PACKER -- requirements
Module: frame_packer

Interface
REQ-001 Parameter INSTR_W, default 64: instruction word width in bits.
REQ-002 Parameter SLOTS, default 16: words per frame; slot 0 is the header and slots 1..SLOTS-1 hold instructions.
REQ-003 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port instr_valid, input, 1: an instruction is offered.
REQ-006 Port instr_ready, output, 1: the packer accepts the instruction this cycle.
REQ-007 Port instr_data, input, INSTR_W: instruction word.
REQ-008 Port instr_fence, input, 2: barrier code for the frame, sampled with the first instruction of the frame.
REQ-009 Port instr_last, input, 1: the accepted instruction closes the current frame.
REQ-010 Port frame_valid, output, 1: a complete frame is presented.
REQ-011 Port frame_ready, input, 1: the scheduler takes the frame.
REQ-012 Port frame_data, output, SLOTS*INSTR_W: frame contents; slot k occupies bits [k*INSTR_W +: INSTR_W].
REQ-013 Port frame_count, output, 16: number of frames handed off, wrapping modulo 2^16.

Function
REQ-014 A handshake occurs when valid and ready are both 1 on a rising edge; this rule applies to both the input and output sides.
REQ-015 Assembly states:
- FILL: accumulating instructions.
- CLOSED: frame complete, waiting for the output register.
REQ-016 In FILL, each accepted instruction is written to slot 1+n, where n is the count of instructions accepted so far in the frame.
- The first accepted instruction also latches instr_fence.
REQ-017 The frame closes on the handshake carrying instr_last=1, or on the handshake filling slot SLOTS-1, whichever occurs first.
REQ-018 Header word layout:
- bits [7:6] = latched fence.
- bits [5:0] = instruction count (1..SLOTS-1).
- all other header bits = 0.
REQ-019 Slots not written in a frame SHALL be 0 in frame_data.
REQ-020 Close-and-transfer rule:
- On close, the frame moves to the output register on the same edge if the output register is empty or is handshaking that cycle.
- Otherwise the state goes to CLOSED.
REQ-021 In CLOSED, instr_ready=0; the transfer happens on the first edge where the output register is empty or handshaking, then the state returns to FILL.
REQ-022 In FILL, instr_ready=1; the output stall affects only the CLOSED state.
REQ-023 The assembly buffer and count SHALL clear on transfer, so the next frame starts at slot 1 with zeroed slots.
REQ-024 frame_valid rises the edge after transfer, so latency from the closing input handshake to frame_valid is 1 cycle.
REQ-025 frame_data and frame_valid SHALL hold stable while frame_valid=1 and frame_ready=0.
REQ-026 frame_count increments by 1 on each output handshake and wraps from 0xFFFF to 0x0000.
REQ-027 frame_ready=1 while frame_valid=0 has no effect.

Reset
REQ-028 Asserting reset_n=0 SHALL immediately force the following, including mid-frame and mid-stall; partially assembled frames are discarded:
- frame_valid=0, frame_data=0, frame_count=0.
- state FILL, count 0, fence 0, assembly buffer 0.
REQ-029 While reset_n=0, instr_ready=0; after deassertion, instr_ready=1 from the first clock edge.

Configuration
REQ-030 With macro FRAME_PACKER_FLUSH_EN defined:
- An extra input port flush (1 bit) is present.
- flush=1 in FILL with count>=1 closes the frame on that edge exactly as instr_last would (REQ-020).
- If an instruction handshake happens the same cycle, that instruction is included before closing.
- flush with count 0 and no handshake is ignored.
REQ-031 Without FRAME_PACKER_FLUSH_EN, the flush port does not exist, and frames close only per REQ-017.

Verification
REQ-032 Send 3 instructions 0xA, 0xB, 0xC with fence=2, last on the third, frame_ready=1 -> one cycle later:
- frame_valid=1, header=0x83.
- slots 1..3 = 0xA, 0xB, 0xC; slots 4..15 = 0.
- frame_count=1 after the handshake.
REQ-033 Send 15 instructions with no last -> frame closes on the 15th, header[5:0]=15; the 16th instruction starts a new frame at slot 1.
REQ-034 Hold frame_ready=0, complete a second frame -> state CLOSED, instr_ready=0, first frame stable; raise frame_ready -> second frame presented the next cycle and instr_ready returns to 1.
REQ-035 Pulse reset_n low mid-frame after 5 instructions -> outputs zero immediately; the next frame's header count starts from the first post-reset instruction.
REQ-036 Preset frame_count=0xFFFF via 65535 handshakes, then perform one more -> frame_count=0x0000.
REQ-037 With FRAME_PACKER_FLUSH_EN: 2 instructions then flush -> header count 2; flush with an empty frame -> no frame_valid.

Source files
------------

// File: rtl/frame_packer.sv
// Packs instruction words into SLOTS-word frames (header in slot 0) behind a one-deep output register.
// Optional FRAME_PACKER_FLUSH_EN adds a flush input that closes a non-empty frame early.
module frame_packer #(
  parameter int INSTR_W = 64,
  parameter int SLOTS   = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       instr_valid,
  output logic                       instr_ready,
  input  logic [INSTR_W-1:0]         instr_data,
  input  logic [1:0]                 instr_fence,
  input  logic                       instr_last,
`ifdef FRAME_PACKER_FLUSH_EN
  input  logic                       flush,
`endif
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic [SLOTS*INSTR_W-1:0]   frame_data,
  output logic [15:0]                frame_count
);

  // state  | meaning
  // FILL   | accepting instructions into the assembly buffer
  // CLOSED | frame complete, waiting for the output register to free up

  localparam int CW = $clog2(SLOTS);
  localparam int FW = SLOTS * INSTR_W;

  typedef enum logic {FILL, CLOSED} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      fence_q, fence_d;
  logic [FW-1:0]   asm_q, asm_d, frame_d;
  logic            ready_q, valid_q;
  logic [FW-1:0]   data_q;
  logic [15:0]     count_q;
  logic            in_hs, out_hs, out_free, close, xfer, flush_w;

`ifdef FRAME_PACKER_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  always_comb begin
    in_hs    = instr_valid & ready_q;
    out_hs   = valid_q & frame_ready;
    out_free = ~valid_q | frame_ready;
    asm_d    = asm_q;
    cnt_d    = cnt_q;
    fence_d  = fence_q;
    if (in_hs) begin
      asm_d[(int'(cnt_q) + 1) * INSTR_W +: INSTR_W] = instr_data;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '0) fence_d = instr_fence;
    end
    // A flush is folded in after any same-cycle instruction so that word lands in the frame.
    close = (state_q == FILL) &
            ((in_hs & (instr_last | (cnt_d == CW'(SLOTS - 1)))) |
             (flush_w & (cnt_d != '0)));
    xfer  = ((state_q == CLOSED) | close) & out_free;
    state_d = state_q;
    if (xfer)       state_d = FILL;
    else if (close) state_d = CLOSED;
    frame_d       = asm_d;
    frame_d[7:0]  = {fence_d, 6'(cnt_d)};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      fence_q <= '0;
      asm_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == FILL);
      if (xfer) begin
        asm_q   <= '0;
        cnt_q   <= '0;
        fence_q <= '0;
        valid_q <= 1'b1;
        data_q  <= frame_d;
      end else begin
        asm_q   <= asm_d;
        cnt_q   <= cnt_d;
        fence_q <= fence_d;
        if (out_hs) valid_q <= 1'b0;
      end
      if (out_hs) count_q <= count_q + 16'd1;
    end
  end

  assign instr_ready = ready_q;
  assign frame_valid = valid_q;
  assign frame_data  = data_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_frame_packer.sv
// Directed bench for frame_packer: scoreboard of expected frames checked on every output handshake.
module tb_frame_packer;
  localparam int W  = 64;
  localparam int S  = 16;
  localparam int FW = W * S;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [W-1:0]  instr_data = '0;
  logic [1:0]    instr_fence = '0;
  logic          instr_last = 1'b0;
  logic          frame_valid;
  logic          frame_ready = 1'b0;
  logic [FW-1:0] frame_data;
  logic [15:0]   frame_count;
`ifdef FRAME_PACKER_FLUSH_EN
  logic          flush = 1'b0;
`endif

  frame_packer #(.INSTR_W(W), .SLOTS(S)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_fence (instr_fence),
    .instr_last  (instr_last),
`ifdef FRAME_PACKER_FLUSH_EN
    .flush       (flush),
`endif
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_count (frame_count)
  );

  always #5 clock = ~clock;

  int            n_cmp = 0;
  int            n_fail = 0;
  logic [FW-1:0] sbq[$];
  logic [FW-1:0] mon_exp;
  logic [W-1:0]  m_slots [S];
  int            m_cnt;
  logic [1:0]    m_fence;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] model_frame();
    logic [FW-1:0] f;
    f = '0;
    f[7:0] = {m_fence, 6'(m_cnt)};
    for (int k = 1; k < S; k++) f[k*W +: W] = m_slots[k];
    return f;
  endfunction

  function automatic int first_diff(input logic [FW-1:0] a, input logic [FW-1:0] b);
    for (int k = 0; k < S; k++) if (a[k*W +: W] !== b[k*W +: W]) return k;
    return 0;
  endfunction

  task automatic model_clear();
    m_cnt = 0;
    m_fence = '0;
    for (int k = 0; k < S; k++) m_slots[k] = '0;
  endtask

  task automatic model_close();
    if (m_cnt > 0) begin
      sbq.push_back(model_frame());
      model_clear();
    end
  endtask

  task automatic model_accept(input logic [W-1:0] d, input logic [1:0] f, input logic last);
    if (m_cnt == 0) m_fence = f;
    m_cnt++;
    m_slots[m_cnt] = d;
    if (last || m_cnt == S - 1) model_close();
  endtask

  // Called just after a rising edge; returns just after the edge carrying the handshake.
  task automatic send(input logic [W-1:0] d, input logic [1:0] f, input logic last);
    int t;
    t = 0;
    instr_valid = 1'b1;
    instr_data  = d;
    instr_fence = f;
    instr_last  = last;
    @(negedge clock);
    while (!instr_ready && t < 50) begin
      t++;
      @(negedge clock);
    end
    if (!instr_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout instr_ready=%b required=1", instr_ready);
    end else begin
      model_accept(d, f, last);
    end
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    instr_last  = 1'b0;
  endtask

  always @(negedge clock) begin
    if (reset_n && frame_valid && frame_ready) begin
      n_cmp++;
      assert (sbq.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_underflow frame_valid=1 expected_frames=0");
      end
      if (sbq.size() != 0) begin
        mon_exp = sbq.pop_front();
        assert (frame_data === mon_exp) else begin
          n_fail++;
          $error("FAIL sb_frame slot%0d got=%h exp=%h", first_diff(frame_data, mon_exp),
                 frame_data[first_diff(frame_data, mon_exp)*W +: W],
                 mon_exp[first_diff(frame_data, mon_exp)*W +: W]);
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog time_limit_reached required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    #2;
    chk("rst_ready", 64'(instr_ready), 64'd0);
    chk("rst_valid", 64'(frame_valid), 64'd0);
    chk("rst_count", 64'(frame_count), 64'd0);
    chk("rst_data",  64'(|frame_data), 64'd0);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready_held", 64'(instr_ready), 64'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("ready_after_rst", 64'(instr_ready), 64'd1);

    // Basic three-word frame
    frame_ready = 1'b1;
    send(64'hA, 2'd2, 1'b0);
    send(64'hB, 2'd2, 1'b0);
    send(64'hC, 2'd2, 1'b1);
    chk("f1_valid", 64'(frame_valid), 64'd1);
    chk("f1_header", frame_data[W-1:0], 64'h83);
    @(posedge clock);
    #1;
    chk("f1_count", 64'(frame_count), 64'd1);
    chk("f1_valid_drop", 64'(frame_valid), 64'd0);

    // Full frame closes on slot SLOTS-1, next word restarts at slot 1
    for (int i = 1; i <= 15; i++) send(64'h100 + 64'(i), 2'd1, 1'b0);
    chk("full_header", frame_data[W-1:0], 64'h4F);
    send(64'h200, 2'd3, 1'b1);
    chk("after_full_header", frame_data[W-1:0], 64'hC1);
    chk("after_full_slot1", frame_data[2*W-1:W], 64'h200);
    @(posedge clock);
    #1;
    chk("after_full_count", 64'(frame_count), 64'd3);

    // Output stall: second frame parks in CLOSED
    frame_ready = 1'b0;
    send(64'h300, 2'd0, 1'b0);
    send(64'h301, 2'd0, 1'b1);
    send(64'h310, 2'd1, 1'b0);
    send(64'h311, 2'd1, 1'b0);
    send(64'h312, 2'd1, 1'b1);
    chk("stall_ready", 64'(instr_ready), 64'd0);
    chk("stall_header", frame_data[W-1:0], 64'h02);
    repeat (3) @(posedge clock);
    #1;
    chk("stall_hold_valid", 64'(frame_valid), 64'd1);
    chk("stall_hold_header", frame_data[W-1:0], 64'h02);
    chk("stall_hold_slot1", frame_data[2*W-1:W], 64'h300);
    chk("stall_hold_ready", 64'(instr_ready), 64'd0);
    chk("stall_hold_count", 64'(frame_count), 64'd3);
    frame_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("unstall_valid", 64'(frame_valid), 64'd1);
    chk("unstall_header", frame_data[W-1:0], 64'h43);
    chk("unstall_ready", 64'(instr_ready), 64'd1);
    chk("unstall_count", 64'(frame_count), 64'd4);
    @(posedge clock);
    #1;
    chk("unstall_count2", 64'(frame_count), 64'd5);

    // Reset in the middle of a frame
    for (int i = 0; i < 5; i++) send(64'h700 + 64'(i), 2'd3, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(frame_valid), 64'd0);
    chk("midrst_data",  64'(|frame_data), 64'd0);
    chk("midrst_count", 64'(frame_count), 64'd0);
    chk("midrst_ready", 64'(instr_ready), 64'd0);
    model_clear();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    send(64'h400, 2'd1, 1'b0);
    send(64'h401, 2'd1, 1'b1);
    chk("postrst_header", frame_data[W-1:0], 64'h42);
    @(posedge clock);
    #1;
    chk("postrst_count", 64'(frame_count), 64'd1);

    // Stream one-word frames until frame_count reaches 0xFFFF, then wrap
    instr_valid = 1'b1;
    instr_last  = 1'b1;
    instr_fence = 2'd0;
    for (int i = 0; i < 65534; i++) begin
      instr_data = 64'(i) ^ 64'h5A5A_0000_0000_0000;
      model_accept(instr_data, 2'd0, 1'b1);
      @(posedge clock);
      #1;
    end
    instr_valid = 1'b0;
    instr_last  = 1'b0;
    @(posedge clock);
    #1;
    chk("count_ffff", 64'(frame_count), 64'hFFFF);
    send(64'h500, 2'd0, 1'b1);
    @(posedge clock);
    #1;
    chk("count_wrap", 64'(frame_count), 64'd0);

`ifdef FRAME_PACKER_FLUSH_EN
    send(64'h600, 2'd2, 1'b0);
    send(64'h601, 2'd2, 1'b0);
    flush = 1'b1;
    model_close();
    @(posedge clock);
    #1;
    flush = 1'b0;
    chk("flush_valid", 64'(frame_valid), 64'd1);
    chk("flush_header", frame_data[W-1:0], 64'h82);
    @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    chk("flush_empty_valid", 64'(frame_valid), 64'd0);
    chk("flush_empty_ready", 64'(instr_ready), 64'd1);
`endif

    repeat (3) @(posedge clock);
    #1;
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
